// File: rtl/pow_2_seq.sv
// Iterative left-shift scaler: out_result = base << exp, one shift per clock,
// with early exit once the accumulator has shifted down to zero.
module pow_2_seq #(
    parameter int WIDTH = 32,
    parameter int EXP_W = 6,
    parameter int CNT_W = EXP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_base,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // BUSY  | shifting acc left one bit per cycle, cnt counting down
    // DONE  | result held on the outputs until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [WIDTH-1:0] acc_shl;
    logic             zero_req;
    logic             last_shift;

    assign acc_shl    = {acc[WIDTH-2:0], 1'b0};
    assign zero_req   = (in_exp == '0) || (in_base == '0);
    // Once acc_shl is zero no later shift can change acc or ovf, so stop early.
    assign last_shift = (cnt == CNT_W'(1)) || (acc_shl == '0);

    assign in_ready     = (state == IDLE) && rst_n;
    assign out_valid    = (state == DONE);
    assign out_result   = acc;
    assign out_overflow = ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= in_base;
                        cnt   <= CNT_W'(in_exp);
                        ovf   <= 1'b0;
                        state <= zero_req ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    ovf <= ovf | acc[WIDTH-1];
                    acc <= acc_shl;
                    cnt <= cnt - CNT_W'(1);
                    if (last_shift) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pow_2_seq.sv
// Bench for pow_2_seq: directed cases plus random requests against a
// wide-arithmetic reference of base * 2^exp.
module tb_pow_2_seq;

    localparam int WIDTH = 32;
    localparam int EXP_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_base;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    pow_2_seq #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_base      (in_base),
        .in_exp       (in_exp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    endtask

    // Reference: the exact product base * 2^exp in a wide integer.
    function automatic logic [127:0] ref_product(input logic [WIDTH-1:0] b, input int e);
        logic [127:0] w;
        w = 128'(b);
        return w << e;
    endfunction

    function automatic int ref_cycles(input logic [WIDTH-1:0] b, input int e);
        int ctz;
        if (b == 0 || e == 0) return 1;
        ctz = 0;
        while (b[ctz] == 1'b0) ctz++;
        return 1 + ((e < WIDTH - ctz) ? e : WIDTH - ctz);
    endfunction

    // Issue one request, measure latency, hold backpressure for `hold` cycles,
    // then complete the output handshake.
    task automatic run_op(input logic [WIDTH-1:0] b, input int e, input int hold, input string tag);
        logic [127:0] prod;
        logic [WIDTH-1:0] want_res;
        logic want_ovf;
        int lat;
        prod     = ref_product(b, e);
        want_res = prod[WIDTH-1:0];
        want_ovf = |prod[127:WIDTH];

        @(negedge clk);
        check({tag, "_ready_idle"}, 64'(in_ready), 64'd1);
        in_base   = b;
        in_exp    = EXP_W'(e);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_base  = $urandom;
        in_exp   = EXP_W'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(ref_cycles(b, e)));
        check({tag, "_result"}, 64'(out_result), 64'(want_res));
        check({tag, "_ovf"}, 64'(out_overflow), 64'(want_ovf));
        for (int i = 0; i < hold; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                in_base  = 32'h1234_5678;
                in_exp   = 6'd3;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_result"}, 64'(out_result), 64'(want_res));
            check({tag, "_hold_ovf"}, 64'(out_overflow), 64'(want_ovf));
            check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_release_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] rb;
        int re;
        int seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_base   = '0;
        in_exp    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready_low", 64'(in_ready), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_ovf", 64'(out_overflow), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready_high", 64'(in_ready), 64'd1);

        run_op(32'd3, 4, 0, "b3e4");
        run_op(32'h8000_0001, 1, 0, "msb_out");
        run_op(32'd0, 31, 0, "zero_base");
        run_op(32'd5, 0, 0, "zero_exp");
        run_op(32'd1, 40, 0, "early_exit");
        run_op(32'h0000_00FF, 28, 10, "backpressure");
        run_op(32'hFFFF_FFFF, 63, 0, "max_exp");

        // Abandon a long request with reset in the middle of shifting.
        @(negedge clk);
        in_base  = 32'd1;
        in_exp   = 6'd20;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ready_low", 64'(in_ready), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_result", 64'(out_result), 64'd0);
        check("abort_ovf", 64'(out_overflow), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        run_op(32'd2, 2, 0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            rb = $urandom;
            if (i % 3 == 0) rb = rb << $urandom_range(0, 31);
            if (i % 5 == 0) rb = rb >> $urandom_range(0, 31);
            if (i % 11 == 0) rb = '0;
            re = $urandom_range(0, 63);
            run_op(rb, re, $urandom_range(0, 4), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
